// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_PULSE,
    ADDR_HOLD,
    GAP,
    DATA_PULSE,
    DATA_HOLD,
    DONE
  } state_t;

  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_T_ADDR_SETUP = 1;
  localparam int unsigned DEF_T_ADDR_PULSE = 5;
  localparam int unsigned DEF_T_ADDR_HOLD  = 1;
  localparam int unsigned DEF_T_GAP        = 5;
  localparam int unsigned DEF_T_DATA_PULSE = 6;
  localparam int unsigned DEF_T_DATA_HOLD  = 1;
  localparam int unsigned DEF_CNT_W        = 5;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  // A phase length is usable when nonzero and its reload value (t-1) fits the counter.
  function automatic bit timing_ok(input int unsigned t, input int unsigned cnt_w);
    return (t != 0) && (t <= (32'd1 << cnt_w));
  endfunction

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; expire flags a count of zero.
module rtc_phase_timer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_count,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire = (count_q == '0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// RTC multiplexed address/data bus sequencer: one address phase and one data phase per request.
// Optional burst transfers are enabled by defining RTC_BURST_EN.
module rtc_bus_sequencer
  import rtc_bus_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned T_ADDR_SETUP = DEF_T_ADDR_SETUP,
  parameter int unsigned T_ADDR_PULSE = DEF_T_ADDR_PULSE,
  parameter int unsigned T_ADDR_HOLD  = DEF_T_ADDR_HOLD,
  parameter int unsigned T_GAP        = DEF_T_GAP,
  parameter int unsigned T_DATA_PULSE = DEF_T_DATA_PULSE,
  parameter int unsigned T_DATA_HOLD  = DEF_T_DATA_HOLD,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_count,
`ifdef RTC_BURST_EN
  input  logic [3:0]        burst_len,
  output logic              beat_done,
`endif
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              a_d,
  output logic              cs,
  output logic              wr,
  output logic              rd,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid
);

  if (!(timing_ok(T_ADDR_SETUP, CNT_W) && timing_ok(T_ADDR_PULSE, CNT_W) &&
        timing_ok(T_ADDR_HOLD, CNT_W)  && timing_ok(T_GAP, CNT_W) &&
        timing_ok(T_DATA_PULSE, CNT_W) && timing_ok(T_DATA_HOLD, CNT_W))) begin : g_bad_timing
    $error("rtc_bus_sequencer: every T_* must be nonzero and T_*-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LD_ADDR_SETUP = CNT_W'(T_ADDR_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_ADDR_PULSE = CNT_W'(T_ADDR_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_ADDR_HOLD  = CNT_W'(T_ADDR_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_GAP        = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LD_DATA_PULSE = CNT_W'(T_DATA_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_DATA_HOLD  = CNT_W'(T_DATA_HOLD - 1);

  state_t            state_q, state_d;
  logic              rw_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic              tmr_load, tmr_expire;
  logic [CNT_W-1:0]  tmr_val;
  logic              more_beats;
  logic              accept;

  assign accept = (state_q == IDLE) && start;

`ifdef RTC_BURST_EN
  logic [3:0] remaining_q;
  assign more_beats = (remaining_q != '0);
  assign beat_done  = (state_q == DATA_HOLD) && tmr_expire;
`else
  assign more_beats = 1'b0;
`endif

  rtc_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset_count(reset_count),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .expire     (tmr_expire)
  );

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every phase transition reloads the timer with the length of the phase being entered.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ADDR_SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_ADDR_SETUP;
        end
      end
      ADDR_SETUP: begin
        if (tmr_expire) begin
          state_d  = ADDR_PULSE;
          tmr_load = 1'b1;
          tmr_val  = LD_ADDR_PULSE;
        end
      end
      ADDR_PULSE: begin
        if (tmr_expire) begin
          state_d  = ADDR_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_ADDR_HOLD;
        end
      end
      ADDR_HOLD: begin
        if (tmr_expire) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = LD_GAP;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          state_d  = DATA_PULSE;
          tmr_load = 1'b1;
          tmr_val  = LD_DATA_PULSE;
        end
      end
      DATA_PULSE: begin
        if (tmr_expire) begin
          state_d  = DATA_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_DATA_HOLD;
        end
      end
      DATA_HOLD: begin
        if (tmr_expire) begin
          if (more_beats) begin
            state_d  = ADDR_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_ADDR_SETUP;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_count) begin
    if (reset_count) begin
      rw_q    <= RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifdef RTC_BURST_EN
      remaining_q <= '0;
`endif
    end else begin
      if (accept) begin
        rw_q    <= rw;
        addr_q  <= addr;
        wdata_q <= wdata;
`ifdef RTC_BURST_EN
        remaining_q <= burst_len;
`endif
      end
`ifdef RTC_BURST_EN
      else if ((state_q == DATA_HOLD) && tmr_expire && more_beats) begin
        addr_q      <= addr_q + DATA_W'(1);
        wdata_q     <= wdata;
        remaining_q <= remaining_q - 4'd1;
      end
`endif
      // Sample on the edge ending the last DATA_PULSE cycle, while rd is still low.
      if ((state_q == DATA_PULSE) && tmr_expire && (rw_q == RW_READ)) begin
        rdata_q <= bus_in;
      end
    end
  end

  assign rdata = rdata_q;

  always_comb begin
    a_d         = 1'b1;
    cs          = 1'b1;
    wr          = 1'b1;
    rd          = 1'b1;
    bus_drive   = 1'b0;
    bus_out     = '0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      ADDR_SETUP: begin
        a_d     = 1'b0;
        bus_out = addr_q;
      end
      ADDR_PULSE: begin
        a_d     = 1'b0;
        cs      = 1'b0;
        wr      = 1'b0;
        bus_out = addr_q;
      end
      ADDR_HOLD: begin
        a_d     = 1'b0;
        bus_out = addr_q;
      end
      DATA_PULSE: begin
        bus_drive = 1'b1;
        cs        = 1'b0;
        if (rw_q == RW_WRITE) begin
          wr      = 1'b0;
          bus_out = wdata_q;
        end else begin
          rd = 1'b0;
        end
      end
      DATA_HOLD: begin
        bus_drive = 1'b1;
        if (rw_q == RW_WRITE) begin
          bus_out = wdata_q;
        end
      end
      DONE: begin
        done        = 1'b1;
        rdata_valid = (rw_q == RW_READ);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Scoreboard bench for rtc_bus_sequencer: default timing instance plus a shortened-pulse instance.
module tb_rtc_bus_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_count;
  logic       start, rw, start2, rw2;
  logic [7:0] addr, wdata, bus_in, addr2, wdata2, bus_in2;
  logic [7:0] bus_out, rdata, bus_out2, rdata2;
  logic       bus_drive, a_d, cs, wr, rd, busy, done, rdata_valid;
  logic       bus_drive2, a_d2, cs2, wr2, rd2, busy2, done2, rdata_valid2;
`ifdef RTC_BURST_EN
  logic [3:0] burst_len;
  logic       beat_done, beat_done2;
`endif

  rtc_bus_sequencer u_dut (
    .clk(clk), .reset_count(reset_count),
`ifdef RTC_BURST_EN
    .burst_len(burst_len), .beat_done(beat_done),
`endif
    .start(start), .rw(rw), .addr(addr), .wdata(wdata), .bus_in(bus_in),
    .bus_out(bus_out), .bus_drive(bus_drive), .a_d(a_d), .cs(cs), .wr(wr), .rd(rd),
    .busy(busy), .done(done), .rdata(rdata), .rdata_valid(rdata_valid)
  );

  rtc_bus_sequencer #(
    .T_ADDR_PULSE(2),
    .T_DATA_PULSE(3)
  ) u_fast (
    .clk(clk), .reset_count(reset_count),
`ifdef RTC_BURST_EN
    .burst_len(4'd0), .beat_done(beat_done2),
`endif
    .start(start2), .rw(rw2), .addr(addr2), .wdata(wdata2), .bus_in(bus_in2),
    .bus_out(bus_out2), .bus_drive(bus_drive2), .a_d(a_d2), .cs(cs2), .wr(wr2), .rd(rd2),
    .busy(busy2), .done(done2), .rdata(rdata2), .rdata_valid(rdata_valid2)
  );

  typedef struct {
    bit         rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
    int         k;
    int         lat;
  } xact_t;

  typedef struct {
    int ap;
    int ah;
    int g;
    int dp;
    int dh;
  } bounds_t;

  function automatic bounds_t mk_bounds(int ts, int tp, int th, int tg, int tdp);
    bounds_t b;
    b.ap = 1 + ts;
    b.ah = b.ap + tp;
    b.g  = b.ah + th;
    b.dp = b.g + tg;
    b.dh = b.dp + tdp;
    return b;
  endfunction

  bounds_t B1 = mk_bounds(1, 5, 1, 5, 6);
  bounds_t B2 = mk_bounds(1, 2, 1, 5, 3);

  xact_t q1[$];
  xact_t q2[$];
  xact_t idle_x;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  bit    mon_abort = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // off = cycles since the acceptance edge; off 0 doubles as the idle expectation.
  task automatic check_cycle(input string tag, input xact_t x, input int off, input bounds_t b,
                             input logic [7:0] bo, input logic drv, input logic ad, input logic cs_,
                             input logic wr_, input logic rd_, input logic bsy, input logic dn,
                             input logic rv, input logic [7:0] rdt);
    bit in_ap, in_dp;
    in_ap = (off >= b.ap) && (off < b.ah);
    in_dp = (off >= b.dp) && (off < b.dh);
    chk({tag, ".a_d"}, ad, !((off >= 1) && (off < b.g)));
    chk({tag, ".cs"}, cs_, !(in_ap || in_dp));
    chk({tag, ".wr"}, wr_, !(in_ap || (x.rw && in_dp)));
    chk({tag, ".rd"}, rd_, !(!x.rw && in_dp));
    chk({tag, ".bus_drive"}, drv, (off >= b.dp) && (off < x.lat));
    chk({tag, ".busy"}, bsy, (off >= 1) && (off <= x.lat));
    chk({tag, ".done"}, dn, off == x.lat);
    chk({tag, ".rdata_valid"}, rv, (off == x.lat) && !x.rw);
    if ((off >= 1) && (off < b.ap)) chk({tag, ".bus_out_addr"}, bo, x.addr);
    if (in_dp) chk({tag, ".bus_out_data"}, bo, x.rw ? x.wdata : 8'h00);
    if (off == x.lat) chk({tag, ".rdata"}, rdt, x.rexp);
  endtask

  always @(negedge clk) begin
    if (!mon_abort) begin
      if (q1.size() > 0 && cyc >= q1[0].k) begin
        check_cycle("dut", q1[0], cyc - q1[0].k, B1, bus_out, bus_drive, a_d, cs, wr, rd,
                    busy, done, rdata_valid, rdata);
        if (cyc - q1[0].k >= q1[0].lat) void'(q1.pop_front());
      end else begin
        check_cycle("dut_idle", idle_x, 0, B1, bus_out, bus_drive, a_d, cs, wr, rd,
                    busy, done, rdata_valid, rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (!mon_abort) begin
      if (q2.size() > 0 && cyc >= q2[0].k) begin
        check_cycle("fast", q2[0], cyc - q2[0].k, B2, bus_out2, bus_drive2, a_d2, cs2, wr2, rd2,
                    busy2, done2, rdata_valid2, rdata2);
        if (cyc - q2[0].k >= q2[0].lat) void'(q2.pop_front());
      end else begin
        check_cycle("fast_idle", idle_x, 0, B2, bus_out2, bus_drive2, a_d2, cs2, wr2, rd2,
                    busy2, done2, rdata_valid2, rdata2);
      end
    end
  end

  // Pads present the read value only during DATA_PULSE, its complement otherwise.
  initial begin
    int off;
    bus_in  = 8'h3C;
    bus_in2 = 8'h77;
    forever begin
      @(negedge clk);
      if (q1.size() > 0 && cyc >= q1[0].k && !q1[0].rw) begin
        off    = cyc - q1[0].k;
        bus_in = (off >= B1.dp && off < B1.dh) ? q1[0].rexp : ~q1[0].rexp;
      end else begin
        bus_in = 8'h3C;
      end
    end
  end

  task automatic issue1(input bit r, input logic [7:0] a, input logic [7:0] w,
                        input logic [7:0] rx, output int k);
    xact_t x;
    @(negedge clk);
    rw = r; addr = a; wdata = w; start = 1'b1;
    k = cyc;
    x.rw = r; x.addr = a; x.wdata = w; x.rexp = rx; x.k = k; x.lat = 20;
    q1.push_back(x);
    @(negedge clk);
    start = 1'b0; addr = ~a; wdata = ~w; rw = ~r;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q1.size() > 0 || q2.size() > 0); i++) @(negedge clk);
    chk("drain_q1_empty", q1.size(), 0);
    chk("drain_q2_empty", q2.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    k;
    xact_t x;
    idle_x.rw = 1'b1; idle_x.addr = '0; idle_x.wdata = '0; idle_x.rexp = '0;
    idle_x.k = 0; idle_x.lat = 1000;
    reset_count = 1'b1;
    start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
    start2 = 1'b0; rw2 = 1'b0; addr2 = '0; wdata2 = '0;
`ifdef RTC_BURST_EN
    burst_len = '0;
`endif
    repeat (2) @(negedge clk);
    chk("reset_strobes", {a_d, cs, wr, rd, bus_drive, busy, done, rdata_valid}, 8'b1111_0000);
    chk("reset_bus_out", bus_out, 8'h00);
    chk("reset_rdata", rdata, 8'h00);
    reset_count = 1'b0;
    repeat (2) @(negedge clk);

    issue1(1'b1, 8'h21, 8'h45, 8'h00, k);
    drain();
    issue1(1'b0, 8'h10, 8'h00, 8'hA5, k);
    drain();
    issue1(1'b1, 8'h33, 8'h5C, 8'hA5, k);
    drain();

    // start held high: second acceptance right after the single IDLE cycle.
    @(negedge clk);
    rw = 1'b1; addr = 8'h44; wdata = 8'h99; start = 1'b1;
    k = cyc;
    x.rw = 1'b1; x.addr = 8'h44; x.wdata = 8'h99; x.rexp = 8'hA5; x.lat = 20;
    x.k = k;      q1.push_back(x);
    x.k = k + 21; q1.push_back(x);
    for (int i = 0; i < 40 && cyc < k + 22; i++) @(negedge clk);
    start = 1'b0;
    drain();

    // Abort during the data pulse.
    issue1(1'b1, 8'h55, 8'h66, 8'hA5, k);
    for (int i = 0; i < 40 && cyc < k + 14; i++) @(negedge clk);
    @(posedge clk);
    #1;
    mon_abort = 1'b1;
    q1.delete();
    reset_count = 1'b1;
    #1;
    chk("abort_cs_wr_drive", {cs, wr, bus_drive, busy}, 4'b1100);
    repeat (3) @(negedge clk);
    reset_count = 1'b0;
    mon_abort = 1'b0;
    repeat (25) @(negedge clk);
    issue1(1'b0, 8'h7E, 8'h00, 8'h3D, k);
    drain();

    // Shortened pulses on the second instance.
    @(negedge clk);
    rw2 = 1'b1; addr2 = 8'hAB; wdata2 = 8'hCD; start2 = 1'b1;
    x.rw = 1'b1; x.addr = 8'hAB; x.wdata = 8'hCD; x.rexp = 8'h00; x.k = cyc; x.lat = 14;
    q2.push_back(x);
    @(negedge clk);
    start2 = 1'b0; addr2 = 8'h00; wdata2 = 8'h00;
    drain();

`ifdef RTC_BURST_EN
    begin
      logic [7:0] seen[$];
      logic       prev_ad;
      int         beats, beats2, dones;
      logic [7:0] exp_addr;
      mon_abort = 1'b1;
      beats = 0; beats2 = 0; dones = 0; prev_ad = 1'b1;
      @(negedge clk);
      burst_len = 4'd2; rw = 1'b1; addr = 8'h0E; wdata = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && dones == 0; i++) begin
        if (prev_ad && !a_d) seen.push_back(bus_out);
        prev_ad = a_d;
        beats  += int'(beat_done);
        beats2 += int'(beat_done2);
        dones  += int'(done);
        @(negedge clk);
      end
      chk("burst_addr_count", seen.size(), 3);
      exp_addr = 8'h0E;
      foreach (seen[i]) begin
        chk("burst_addr", seen[i], exp_addr);
        exp_addr = exp_addr + 8'd1;
      end
      chk("burst_beats", beats, 3);
      chk("burst_done", dones, 1);
      chk("fast_no_beats", beats2, 0);
      burst_len = 4'd0;
      repeat (2) @(negedge clk);
      mon_abort = 1'b0;
    end
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Parametrised successor to the RTC control-signal generator. Drives the multiplexed address/data bus of the RTC (a_d, cs, wr, rd, bus direction) through one complete address phase and data phase per request.
- Phase lengths and data width are set by parameters. Adds latched request operands, read-data capture, and busy/done handshake outputs.
- Sits between the RTC register-access controller (above) and the tri-state pad logic (below).

Parameters:
- DATA_W, 8, bus/address/data width
- T_ADDR_SETUP, 1, cycles a_d low before cs falls
- T_ADDR_PULSE, 5, cycles cs+wr low strobing the address
- T_ADDR_HOLD, 1, cycles a_d low after cs/wr rise
- T_GAP, 5, idle cycles (a_d high, strobes high) between phases
- T_DATA_PULSE, 6, cycles cs plus wr (write) or rd (read) low
- T_DATA_HOLD, 1, cycles bus_drive held at 1 after strobes rise
- CNT_W, 5, phase counter width; must hold max(T_*)-1

Ports:
- clk  in  1  clock
- reset_count  in  1  reset
- start  in  1  request; sampled only in IDLE
- rw  in  1  1 = write, 0 = read
- addr  in  DATA_W  RTC register address
- wdata  in  DATA_W  write data
- bus_in  in  DATA_W  value read from the pads
- bus_out  out  DATA_W  value driven onto the pads
- bus_drive  out  1  0 = address phase/idle, 1 = data phase
- a_d  out  1  address/data strobe, active low = address
- cs  out  1  chip select, active low
- wr  out  1  write strobe, active low
- rd  out  1  read strobe, active low
- busy  out  1  high from acceptance through DONE
- done  out  1  1-cycle pulse at end of transfer
- rdata  out  DATA_W  captured read data
- rdata_valid  out  1  1-cycle pulse with done, reads only

Behaviour:
- Reset: reset_count, asynchronous, active-high; clock clk. On reset: state IDLE, phase counter 0, latched operands 0. Outputs a_d=cs=wr=rd=1, bus_drive=0, bus_out=0, busy=done=rdata_valid=0, rdata=0.
- Reset mid-transfer aborts immediately, with all strobes high in the same cycle. No done is issued.
- Acceptance: start=1 in IDLE at edge k. rw, addr and wdata are latched at edge k, and busy=1 from cycle k+1. start is ignored while busy.
- Each phase loads a down-counter with T-1 and advances when the counter reaches 0. All outputs are registered or decoded from the state only, so they are glitch-free.
- IDLE: all strobes high, bus_drive=0.
- ADDR_SETUP: a_d=0, bus_out=addr.
- ADDR_PULSE: a_d=0, cs=0, wr=0 (wr is low for both read and write).
- ADDR_HOLD: a_d=0, cs=wr=1.
- GAP: a_d=1, strobes high, bus_drive=0.
- DATA_PULSE: a_d=1, bus_drive=1, cs=0. wr=0 if write, else rd=0. bus_out=wdata on writes and 0 on reads.
- DATA_HOLD: strobes high, bus_drive=1.
- DONE: one cycle with done=1 and busy=1, then return to IDLE.
- Read capture: rdata <= bus_in at the edge that ends the last DATA_PULSE cycle, while rd is still low. rdata_valid=1 in DONE for reads only. rdata holds its value until the next read.
- Latency with defaults: done is asserted in cycle k+20 (1+5+1+5+6+1 phase cycles, then DONE). In general: k+1+sum(T_*).
- Back-to-back: a start asserted during DONE is not accepted. It is accepted at the first IDLE edge, giving a minimum 1 IDLE cycle between transfers.
- Any T_*=0 is illegal. Flag it with an elaboration-time check. The counter never wraps.

Optional Feature:
- Macro: RTC_BURST_EN.
- With the macro: adds input burst_len[3:0] (latched at acceptance) and output beat_done. After DATA_HOLD, if remaining>0, the latched address is incremented modulo 2^DATA_W, remaining is decremented, and the block re-enters ADDR_SETUP. beat_done pulses at the end of each beat. done and rdata_valid pulse only after the final beat, and rdata holds the last beat's data. burst_len=0 behaves as a single transfer. wdata is resampled at each ADDR_SETUP.
- Without the macro: no burst_len or beat_done ports; single transfer only.

Decomposition:
- Shared package rtc_bus_pkg holds:
  - state enum: IDLE, ADDR_SETUP, ADDR_PULSE, ADDR_HOLD, GAP, DATA_PULSE, DATA_HOLD, DONE
  - default timing constants
  - RW_WRITE/RW_READ encodings
- One sub-module, rtc_phase_timer: loadable CNT_W down-counter with an expire flag.

Test Plan:
- Write, addr=8'h21, wdata=8'h45, start pulse at k:
  - a_d low k+1..k+7
  - cs/wr low k+2..k+6
  - cs/wr low again k+13..k+18 with bus_out=8'h45, bus_drive=1 k+13..k+19
  - done=1 at k+20, rd never low
- Read, addr=8'h10, bus_in=8'hA5 during DATA_PULSE -> rd low k+13..k+18, rdata=8'hA5 and rdata_valid=1 at k+20.
- start held high continuously -> transfers accepted at k and k+21, busy low for exactly one cycle between them.
- reset_count asserted at k+15 of a write -> cs=wr=1 and bus_drive=0 in that cycle, no done; the next start behaves normally.
- Parameters T_ADDR_PULSE=2, T_DATA_PULSE=3 -> done at k+1+1+2+1+5+3+1 = k+14.
- RTC_BURST_EN with burst_len=2, addr=8'h0E -> addresses 0E, 0F, 10 in successive address phases, beat_done three times, done once.
